// File: rtl/sm4_tlul_host.sv
// TL-UL host that drives one complete SM4 job (optional key load, one block) through the SM4 register map.
// Build option: define SM4_HOST_INTG_EN to generate A-channel integrity and check D-channel integrity.

package tlul_pkg;
    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    parameter tl_a_user_t TL_A_USER_DEFAULT = '0;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // 7-bit XOR fold shared by command, response and data integrity
    function automatic logic [6:0] intg_fold(input logic [63:0] x);
        logic [6:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) r[i % 7] = r[i % 7] ^ x[i];
        return r;
    endfunction
endpackage

module sm4_tlul_host #(
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter logic [31:0] CTRL_OFFSET   = 32'h00,
    parameter logic [31:0] STATE_OFFSET  = 32'h04,
    parameter logic [31:0] KEY_OFFSET    = 32'h08,
    parameter logic [31:0] DATA_OFFSET   = 32'h18,
    parameter logic [31:0] RESULT_OFFSET = 32'h28,
    parameter logic [7:0]  SOURCE_ID     = 8'h0,
    parameter logic [15:0] POLL_LIMIT    = 16'd1024
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output tlul_pkg::tl_h2d_t   tl_o,
    input  tlul_pkg::tl_d2h_t   tl_i,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  logic                job_load_key_i,
    input  logic [127:0]        job_key_i,
    input  logic                job_decrypt_i,
    input  logic [127:0]        job_data_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [127:0]        res_data_o,
    output logic                res_err_o,
    output logic                busy_o
);
    typedef enum logic [3:0] {
        IDLE, WR_KEY, KEXP_GO, KEXP_POLL, KEXP_END, WR_DATA,
        CLR_STATE, GO, DROP, DONE_POLL, RD_RES, RESP
    } state_e;

    state_e        state_q, state_d;
    logic [127:0]  key_q, key_d, data_q, data_d, res_q, res_d;
    logic          dec_q, dec_d, err_q, err_d;
    logic          a_valid_q, a_valid_d, outst_q, outst_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   poll_q, poll_d;

    logic          bus_state, is_read, rsp_done, rsp_err;
    logic [31:0]   offset, wdata;
    logic          unused_tl;

    // Address/data are pure functions of state and word index, so they stay stable while a_valid waits
    always_comb begin
        bus_state = 1'b1;
        is_read   = 1'b0;
        offset    = CTRL_OFFSET;
        wdata     = '0;
        case (state_q)
            WR_KEY: begin
                offset = KEY_OFFSET + {28'd0, idx_q, 2'b00};
                wdata  = key_q[{idx_q, 5'd0} +: 32];
            end
            KEXP_GO:  wdata = 32'h0000_0031;
            KEXP_POLL, DONE_POLL: begin
                offset  = STATE_OFFSET;
                is_read = 1'b1;
            end
            KEXP_END: wdata = 32'h0000_0011;
            WR_DATA: begin
                offset = DATA_OFFSET + {28'd0, idx_q, 2'b00};
                wdata  = data_q[{idx_q, 5'd0} +: 32];
            end
            CLR_STATE: offset = STATE_OFFSET;
            GO:        wdata  = {28'd0, 1'b1, dec_q, 2'b11};
            DROP:      wdata  = {28'd0, 1'b0, dec_q, 2'b11};
            RD_RES: begin
                offset  = RESULT_OFFSET + {28'd0, idx_q, 2'b00};
                is_read = 1'b1;
            end
            default: bus_state = 1'b0;
        endcase
    end

    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = is_read ? 3'h4 : 3'h0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = SOURCE_ID;
        tl_o.a_address = BASE_ADDR + offset;
        tl_o.a_mask    = 4'hF;
        tl_o.a_data    = is_read ? 32'h0 : wdata;
`ifdef SM4_HOST_INTG_EN
        tl_o.a_user.cmd_intg  = tlul_pkg::intg_fold({23'd0, tl_o.a_opcode, tl_o.a_address,
                                                     tl_o.a_mask, tl_o.a_size});
        tl_o.a_user.data_intg = tlul_pkg::intg_fold({32'd0, tl_o.a_data});
`else
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
`endif
        tl_o.d_ready   = 1'b1;
    end

`ifdef SM4_HOST_INTG_EN
    assign rsp_err = tl_i.d_error
        || (tl_i.d_user.rsp_intg  != tlul_pkg::intg_fold({58'd0, tl_i.d_opcode, tl_i.d_size, tl_i.d_error}))
        || (tl_i.d_user.data_intg != tlul_pkg::intg_fold({32'd0, tl_i.d_data}));
`else
    assign rsp_err = tl_i.d_error;
`endif

    assign rsp_done  = outst_q && tl_i.d_valid;
    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_user};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        data_d    = data_q;
        res_d     = res_q;
        dec_d     = dec_q;
        err_d     = err_q;
        a_valid_d = a_valid_q;
        outst_d   = outst_q;
        idx_d     = idx_q;
        poll_d    = poll_q;

        if (a_valid_q && tl_i.a_ready) begin
            a_valid_d = 1'b0;
            outst_d   = 1'b1;
        end else if (bus_state && !a_valid_q && !outst_q) begin
            a_valid_d = 1'b1;
        end

        if (rsp_done) begin
            outst_d = 1'b0;
            if (rsp_err) begin
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                case (state_q)
                    WR_KEY: begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = KEXP_GO;
                    end
                    KEXP_GO: begin
                        state_d = KEXP_POLL;
                        poll_d  = '0;
                    end
                    KEXP_POLL, DONE_POLL: begin
                        if (state_q == KEXP_POLL ? tl_i.d_data[1] : tl_i.d_data[0]) begin
                            state_d = (state_q == KEXP_POLL) ? KEXP_END : RD_RES;
                        end else begin
                            poll_d = poll_q + 16'd1;
                            if (poll_q + 16'd1 == POLL_LIMIT) begin
                                err_d   = 1'b1;
                                state_d = RESP;
                            end
                        end
                    end
                    KEXP_END: state_d = WR_DATA;
                    WR_DATA: begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = CLR_STATE;
                    end
                    CLR_STATE: state_d = GO;
                    GO:        state_d = DROP;
                    DROP: begin
                        state_d = DONE_POLL;
                        poll_d  = '0;
                    end
                    RD_RES: begin
                        res_d[{idx_q, 5'd0} +: 32] = tl_i.d_data;
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) state_d = RESP;
                    end
                    default: ;
                endcase
            end
        end

        case (state_q)
            IDLE: if (job_valid_i) begin
                key_d   = job_key_i;
                data_d  = job_data_i;
                dec_d   = job_decrypt_i;
                err_d   = 1'b0;
                idx_d   = '0;
                state_d = job_load_key_i ? WR_KEY : WR_DATA;
            end
            RESP: if (res_ready_i) state_d = IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            key_q     <= '0;
            data_q    <= '0;
            res_q     <= '0;
            dec_q     <= 1'b0;
            err_q     <= 1'b0;
            a_valid_q <= 1'b0;
            outst_q   <= 1'b0;
            idx_q     <= '0;
            poll_q    <= '0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            data_q    <= data_d;
            res_q     <= res_d;
            dec_q     <= dec_d;
            err_q     <= err_d;
            a_valid_q <= a_valid_d;
            outst_q   <= outst_d;
            idx_q     <= idx_d;
            poll_q    <= poll_d;
        end
    end

    assign job_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == RESP);
    assign res_data_o  = res_q;
    assign res_err_o   = err_q;
endmodule
